reg_wb_ctrl: RTL

Write-back controller directly upstream of the CPU register file. It merges ALU results and memory load responses into the register file's single write port (we / adr_wrt / data_in). It aligns and sign/zero-extends load data, buffers load responses while the ALU owns the port, and keeps a pending-load scoreboard for issue/hazard logic.

---
 rtl/reg_wb_ctrl_if.sv | 33 +++
 rtl/reg_wb_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle between the issue/ALU/memory side and the register-file write-back controller.
// master drives requests and load responses; slave is the write-back controller.
interface reg_wb_ctrl_if;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_rsp_vld;
    logic        ld_rsp_rdy;
    logic [4:0]  ld_rsp_rd;
    logic [31:0] ld_rsp_data;
    logic [1:0]  ld_rsp_size;
    logic        ld_rsp_sext;
    logic [1:0]  ld_rsp_off;
    logic        rf_we;
    logic [4:0]  rf_adr_wrt;
    logic [31:0] rf_data_in;
    logic [31:0] busy_mask;
    logic        waw_err;

    modport master (
        output alu_vld, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_rsp_vld, ld_rsp_rd, ld_rsp_data, ld_rsp_size, ld_rsp_sext, ld_rsp_off,
        input  ld_rsp_rdy, rf_we, rf_adr_wrt, rf_data_in, busy_mask, waw_err
    );

    modport slave (
        input  alu_vld, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_rsp_vld, ld_rsp_rd, ld_rsp_data, ld_rsp_size, ld_rsp_sext, ld_rsp_off,
        output ld_rsp_rdy, rf_we, rf_adr_wrt, rf_data_in, busy_mask, waw_err
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU-priority merge of ALU results and queued loads,
// pending-load scoreboard and sticky WAW flag. Define LD_EXT_EN to align/extend load data.
module reg_wb_ctrl #(
    parameter int LQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_wb_ctrl_if.slave  bus
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lq_ent_t;

    lq_ent_t        r_lq [LQ_DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [CW-1:0]  r_cnt;
    logic           r_we;
    logic [4:0]     r_adr;
    logic [31:0]    r_data;
    logic [31:0]    r_busy;
    logic           r_waw;

    logic           w_push, w_pop, w_rdy;
    logic [31:0]    w_ld_data;
    logic           w_sel_vld;
    logic [4:0]     w_sel_rd;
    logic [31:0]    w_sel_data;
    logic [31:0]    w_busy_nxt;
    logic           w_waw;
    lq_ent_t        w_head;

`ifdef LD_EXT_EN
    logic [31:0] w_sh;
    always_comb begin
        w_sh      = bus.ld_rsp_data;
        w_ld_data = bus.ld_rsp_data;
        case (bus.ld_rsp_size)
            2'b00: begin
                w_sh      = bus.ld_rsp_data >> {bus.ld_rsp_off, 3'b000};
                w_ld_data = {{24{bus.ld_rsp_sext & w_sh[7]}}, w_sh[7:0]};
            end
            2'b01: begin
                w_sh      = bus.ld_rsp_data >> {bus.ld_rsp_off[1], 4'b0000};
                w_ld_data = {{16{bus.ld_rsp_sext & w_sh[15]}}, w_sh[15:0]};
            end
            default: w_ld_data = bus.ld_rsp_data;
        endcase
    end
`else
    logic w_unused_ext;
    assign w_unused_ext = ^{bus.ld_rsp_size, bus.ld_rsp_sext, bus.ld_rsp_off};
    assign w_ld_data    = bus.ld_rsp_data;
`endif

    // rdy looks only at occupancy so it never combinationally depends on this cycle's pop
    assign w_rdy  = (r_cnt != CW'(LQ_DEPTH));
    assign w_push = bus.ld_rsp_vld & w_rdy;
    assign w_pop  = ~bus.alu_vld & (r_cnt != '0);
    assign w_head = r_lq[r_rptr];

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (bus.alu_vld) begin
            w_sel_vld  = 1'b1;
            w_sel_rd   = bus.alu_rd;
            w_sel_data = bus.alu_data;
        end else if (w_pop) begin
            w_sel_vld  = 1'b1;
            w_sel_rd   = w_head.rd;
            w_sel_data = w_head.data;
        end
    end

    // Clear before set so a same-cycle reissue to the same rd keeps the bit
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)
            w_busy_nxt[w_head.rd] = 1'b0;
        if (bus.ld_issue && bus.ld_issue_rd != 5'd0)
            w_busy_nxt[bus.ld_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_waw = bus.alu_vld & (bus.alu_rd != 5'd0) & r_busy[bus.alu_rd];

    always_ff @(posedge clk) begin
        if (w_push)
            r_lq[r_wptr] <= '{rd: bus.ld_rsp_rd, data: w_ld_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_adr  <= '0;
            r_data <= '0;
            r_busy <= '0;
            r_waw  <= 1'b0;
        end else begin
            r_we   <= w_sel_vld & (w_sel_rd != 5'd0);
            if (w_sel_vld) begin
                r_adr  <= w_sel_rd;
                r_data <= w_sel_data;
            end
            r_busy <= w_busy_nxt;
            r_waw  <= r_waw | w_waw;
        end
    end

    assign bus.ld_rsp_rdy = w_rdy;
    assign bus.rf_we      = r_we;
    assign bus.rf_adr_wrt = r_adr;
    assign bus.rf_data_in = r_data;
    assign bus.busy_mask  = r_busy;
    assign bus.waw_err    = r_waw;
endmodule
